// File: rtl/mem_rmw_ctrl_if.sv
// Shared types and the bundled CPU-request / memory-port signals of the
// load/store sequencer.
package mem_rmw_pkg;
  typedef logic [31:0] cpu_word;
  typedef enum logic [1:0] {
    MEM_W = 2'd0,
    MEM_H = 2'd1,
    MEM_B = 2'd2
  } mem_mode;
endpackage

interface mem_rmw_if #(
  parameter int ADDR_W = 32
);
  import mem_rmw_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  mem_mode           req_mode;
  logic [ADDR_W-1:0] req_addr;
  cpu_word           req_wdata;

  logic              resp_valid;
  cpu_word           resp_word;
  logic [1:0]        resp_byte_adr;
  mem_mode           resp_mode;
  logic              err_misaligned;
  logic              err_timeout;

  logic [ADDR_W-3:0] mem_adr;
  logic              mem_rd;
  logic              mem_wr;
  cpu_word           mem_wdata;
  cpu_word           mem_rdata;
  logic              mem_ack;

  // slave is the controller's view; master is the CPU + memory environment.
  modport slave (
    input  req_valid, req_write, req_mode, req_addr, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_word, resp_byte_adr, resp_mode,
    output err_misaligned, err_timeout,
    output mem_adr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_mode, req_addr, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_word, resp_byte_adr, resp_mode,
    input  err_misaligned, err_timeout,
    input  mem_adr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Load/store sequencer for a word-wide memory port without byte enables:
// sub-word stores are done as read-modify-write.
module mem_rmw_ctrl
  import mem_rmw_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BUS_TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst,
  mem_rmw_if.slave bus
);

  localparam int TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } ctrlState;

  ctrlState          state;
  ctrlState          nextState;

  logic [ADDR_W-1:0] addrReg;
  mem_mode           modeReg;
  logic              writeReg;
  logic [15:0]       wdataReg;
  cpu_word           wordReg;
  cpu_word           respWordReg;
  logic [1:0]        respByteReg;
  mem_mode           respModeReg;
  logic              errMisReg;
  logic              errToReg;
  logic [TW-1:0]     timer;

  logic              accept;
  logic              misaligned;
  logic              timeoutHit;
  cpu_word           mergedWord;

  assign accept     = bus.req_valid && (state == IDLE);
  assign misaligned = ((bus.req_mode == MEM_H) && bus.req_addr[0]) ||
                      ((bus.req_mode == MEM_W) && (bus.req_addr[1:0] != 2'b00));
  assign timeoutHit = (BUS_TIMEOUT != 0) && !bus.mem_ack && (timer == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            nextState = RESP;
          end else if (bus.req_write && (bus.req_mode == MEM_W)) begin
            nextState = WR;
          end else begin
            nextState = RD;
          end
        end
      end
      RD: begin
        if (bus.mem_ack) begin
          nextState = writeReg ? WR : RESP;
        end else if (timeoutHit) begin
          nextState = RESP;
        end
      end
      WR: begin
        if (bus.mem_ack || timeoutHit) begin
          nextState = RESP;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Overlay the store data onto the fetched word; untouched lanes keep the read value.
  always_comb begin
    mergedWord = bus.mem_rdata;
    if (modeReg == MEM_B) begin
      case (addrReg[1:0])
        2'd0:    mergedWord[7:0]   = wdataReg[7:0];
        2'd1:    mergedWord[15:8]  = wdataReg[7:0];
        2'd2:    mergedWord[23:16] = wdataReg[7:0];
        default: mergedWord[31:24] = wdataReg[7:0];
      endcase
    end else if (modeReg == MEM_H) begin
      if (addrReg[1]) begin
        mergedWord[31:16] = wdataReg;
      end else begin
        mergedWord[15:0] = wdataReg;
      end
    end
  end

  // Response fields only change on the way into RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      addrReg     <= '0;
      modeReg     <= MEM_W;
      writeReg    <= 1'b0;
      wdataReg    <= '0;
      wordReg     <= '0;
      respWordReg <= '0;
      respByteReg <= '0;
      respModeReg <= MEM_W;
      errMisReg   <= 1'b0;
      errToReg    <= 1'b0;
      timer       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addrReg   <= bus.req_addr;
            modeReg   <= bus.req_mode;
            writeReg  <= bus.req_write;
            wdataReg  <= bus.req_wdata[15:0];
            wordReg   <= bus.req_wdata;
            errMisReg <= 1'b0;
            errToReg  <= 1'b0;
            timer     <= '0;
            if (misaligned) begin
              errMisReg   <= 1'b1;
              respWordReg <= '0;
              respByteReg <= bus.req_addr[1:0];
              respModeReg <= bus.req_mode;
            end
          end
        end
        RD: begin
          if (bus.mem_ack) begin
            timer <= '0;
            if (writeReg) begin
              wordReg <= mergedWord;
            end else begin
              respWordReg <= bus.mem_rdata;
              respByteReg <= addrReg[1:0];
              respModeReg <= modeReg;
            end
          end else if (timeoutHit) begin
            errToReg    <= 1'b1;
            respWordReg <= '0;
            respByteReg <= addrReg[1:0];
            respModeReg <= modeReg;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WR: begin
          if (bus.mem_ack) begin
            respWordReg <= wordReg;
            respByteReg <= addrReg[1:0];
            respModeReg <= modeReg;
          end else if (timeoutHit) begin
            errToReg    <= 1'b1;
            respWordReg <= '0;
            respByteReg <= addrReg[1:0];
            respModeReg <= modeReg;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.resp_valid     = (state == RESP);
  assign bus.resp_word      = respWordReg;
  assign bus.resp_byte_adr  = respByteReg;
  assign bus.resp_mode      = respModeReg;
  assign bus.err_misaligned = errMisReg;
  assign bus.err_timeout    = errToReg;
  assign bus.mem_adr        = addrReg[ADDR_W-1:2];
  assign bus.mem_rd         = (state == RD);
  assign bus.mem_wr         = (state == WR);
  assign bus.mem_wdata      = wordReg;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Directed bench for mem_rmw_ctrl: a negedge memory responder with programmable
// ack delay, and hand-computed expectations per transaction.
module tb_mem_rmw_ctrl;
  import mem_rmw_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_rmw_if #(.ADDR_W(32)) bus ();

  mem_rmw_ctrl #(.ADDR_W(32), .BUS_TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int          ackDelay = 0;
  bit          ackNever = 0;
  int          waitCnt  = 0;
  int          rdCycles = 0;
  int          wrCycles = 0;
  bit          bothHigh = 0;
  cpu_word     lastWrite = '0;
  logic [29:0] lastAdr = '0;

  cpu_word     seenWord;
  logic [1:0]  seenByte;
  mem_mode     seenMode;
  logic        seenMis;
  logic        seenTo;
  int          lat;

  // Memory model: counts strobe cycles and acks after ackDelay waiting cycles.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_wr) bothHigh = 1;
      if (bus.mem_rd) begin
        rdCycles++;
        lastAdr = bus.mem_adr;
      end
      if (bus.mem_wr) begin
        wrCycles++;
        lastWrite = bus.mem_wdata;
      end
      if ((bus.mem_rd || bus.mem_wr) && !ackNever) begin
        if (waitCnt >= ackDelay) begin
          bus.mem_ack = 1'b1;
          waitCnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          waitCnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        waitCnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One transaction: present the request for one cycle, wait for the response
  // pulse, snapshot the response fields and confirm the pulse is one cycle wide.
  task automatic applyStimulus(input bit wr, input mem_mode mode,
                               input logic [31:0] addr, input cpu_word wdata,
                               output int latency);
    bit expired;
    @(negedge clk);
    checkOutput("readyBeforeReq", {31'b0, bus.req_ready}, 32'd1);
    rdCycles = 0;
    wrCycles = 0;
    bothHigh = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_mode  = mode;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    latency = 1;
    expired = 0;
    while (!bus.resp_valid && !expired) begin
      if (latency >= 50) begin
        expired = 1;
      end else begin
        @(negedge clk);
        latency++;
      end
    end
    checkOutput("respArrived", {31'b0, expired}, 32'd0);
    seenWord = bus.resp_word;
    seenByte = bus.resp_byte_adr;
    seenMode = bus.resp_mode;
    seenMis  = bus.err_misaligned;
    seenTo   = bus.err_timeout;
    @(negedge clk);
    checkOutput("pulseOneCycle", {31'b0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    bit sawWr;
    bit sawResp;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_mode  = MEM_W;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("rstReady", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("rstRd", {31'b0, bus.mem_rd}, 32'd0);
    checkOutput("rstWr", {31'b0, bus.mem_wr}, 32'd0);
    checkOutput("rstRespValid", {31'b0, bus.resp_valid}, 32'd0);
    checkOutput("rstErrMis", {31'b0, bus.err_misaligned}, 32'd0);
    checkOutput("rstErrTo", {31'b0, bus.err_timeout}, 32'd0);
    checkOutput("rstRespWord", bus.resp_word, 32'h0);
    rst = 1'b0;

    // Byte load, immediate ack
    ackDelay = 0;
    bus.mem_rdata = 32'hAABBCCDD;
    applyStimulus(1'b0, MEM_B, 32'h103, 32'h0, lat);
    checkOutput("t1Latency", lat, 32'd2);
    checkOutput("t1RdCycles", rdCycles, 32'd1);
    checkOutput("t1WrCycles", wrCycles, 32'd0);
    checkOutput("t1MemAdr", {2'b0, lastAdr}, 32'h40);
    checkOutput("t1Word", seenWord, 32'hAABBCCDD);
    checkOutput("t1ByteAdr", {30'b0, seenByte}, 32'd3);
    checkOutput("t1Mode", {30'b0, seenMode}, {30'b0, MEM_B});
    checkOutput("t1Mis", {31'b0, seenMis}, 32'd0);

    // Byte store RMW
    bus.mem_rdata = 32'h11223344;
    applyStimulus(1'b1, MEM_B, 32'h101, 32'h0000005A, lat);
    checkOutput("t2Latency", lat, 32'd3);
    checkOutput("t2RdCycles", rdCycles, 32'd1);
    checkOutput("t2WrCycles", wrCycles, 32'd1);
    checkOutput("t2WriteData", lastWrite, 32'h11225A44);
    checkOutput("t2Word", seenWord, 32'h11225A44);
    checkOutput("t2MemAdr", {2'b0, lastAdr}, 32'h40);

    // Half store RMW, ack lands on the last cycle before timeout and must win
    ackDelay = 3;
    applyStimulus(1'b1, MEM_H, 32'h102, 32'h0000BEEF, lat);
    checkOutput("t3Latency", lat, 32'd9);
    checkOutput("t3RdCycles", rdCycles, 32'd4);
    checkOutput("t3WrCycles", wrCycles, 32'd4);
    checkOutput("t3WriteData", lastWrite, 32'hBEEF3344);
    checkOutput("t3ErrTo", {31'b0, seenTo}, 32'd0);
    checkOutput("t3BothHigh", {31'b0, bothHigh}, 32'd0);
    checkOutput("t3Mode", {30'b0, seenMode}, {30'b0, MEM_H});

    // Misaligned word load
    ackDelay = 0;
    applyStimulus(1'b0, MEM_W, 32'h102, 32'h0, lat);
    checkOutput("t4Latency", lat, 32'd1);
    checkOutput("t4RdCycles", rdCycles, 32'd0);
    checkOutput("t4WrCycles", wrCycles, 32'd0);
    checkOutput("t4Mis", {31'b0, seenMis}, 32'd1);
    checkOutput("t4ByteAdr", {30'b0, seenByte}, 32'd2);

    // Word store: single write, misaligned flag cleared by accept
    applyStimulus(1'b1, MEM_W, 32'h104, 32'hCAFEF00D, lat);
    checkOutput("swLatency", lat, 32'd2);
    checkOutput("swRdCycles", rdCycles, 32'd0);
    checkOutput("swWrCycles", wrCycles, 32'd1);
    checkOutput("swWriteData", lastWrite, 32'hCAFEF00D);
    checkOutput("swMis", {31'b0, seenMis}, 32'd0);

    // Misaligned half store
    applyStimulus(1'b1, MEM_H, 32'h101, 32'h00001234, lat);
    checkOutput("mhLatency", lat, 32'd1);
    checkOutput("mhWrCycles", wrCycles, 32'd0);
    checkOutput("mhMis", {31'b0, seenMis}, 32'd1);

    // Bus timeout with BUS_TIMEOUT=4
    ackNever = 1;
    bus.mem_rdata = 32'hDEADBEEF;
    applyStimulus(1'b0, MEM_W, 32'h200, 32'h0, lat);
    checkOutput("t5Latency", lat, 32'd5);
    checkOutput("t5RdCycles", rdCycles, 32'd4);
    checkOutput("t5ErrTo", {31'b0, seenTo}, 32'd1);
    checkOutput("t5Word", seenWord, 32'h0);
    checkOutput("t5Mis", {31'b0, seenMis}, 32'd0);
    ackNever = 0;
    repeat (2) @(negedge clk);
    checkOutput("t5HoldErrTo", {31'b0, bus.err_timeout}, 32'd1);

    // Half load after timeout: error cleared
    bus.mem_rdata = 32'h0F0E0D0C;
    applyStimulus(1'b0, MEM_H, 32'h106, 32'h0, lat);
    checkOutput("hlLatency", lat, 32'd2);
    checkOutput("hlErrTo", {31'b0, seenTo}, 32'd0);
    checkOutput("hlWord", seenWord, 32'h0F0E0D0C);
    checkOutput("hlByteAdr", {30'b0, seenByte}, 32'd2);

    // Reset during the write phase of a byte store
    ackDelay = 2;
    bus.mem_rdata = 32'h11223344;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_mode  = MEM_B;
    bus.req_addr  = 32'h101;
    bus.req_wdata = 32'h5A;
    @(negedge clk);
    bus.req_valid = 1'b0;
    sawWr = 0;
    for (int i = 0; i < 20 && !sawWr; i++) begin
      if (bus.mem_wr) sawWr = 1;
      else @(negedge clk);
    end
    checkOutput("t6WrSeen", {31'b0, sawWr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6WrDropped", {31'b0, bus.mem_wr}, 32'd0);
    checkOutput("t6RdLow", {31'b0, bus.mem_rd}, 32'd0);
    checkOutput("t6NoRespInRst", {31'b0, bus.resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6ReadyAfter", {31'b0, bus.req_ready}, 32'd1);
    sawResp = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.resp_valid || bus.mem_wr || bus.mem_rd) sawResp = 1;
      @(negedge clk);
    end
    checkOutput("t6Abandoned", {31'b0, sawResp}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
